// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary stage of the shift amount per cycle,
// stopping early once no higher amount bits remain, with valid/ready handshakes.
module shift_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned K_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] work, work_nx;
  logic [AMT_W-1:0] amt_r, amt_nx;
  logic [1:0]       op_r, op_nx;
  logic [K_W-1:0]   k, k_nx;

  logic             in_ready_nx, out_valid_nx, busy_nx;
  logic [WIDTH-1:0] out_data_nx;

  logic [AMT_W-1:0] stage_amt;
  logic [WIDTH-1:0] stage_val;
  logic             last_stage;

  // Next-state and datapath for the current stage
  always_comb begin
    state_nx  = state;
    work_nx   = work;
    amt_nx    = amt_r;
    op_nx     = op_r;
    k_nx      = k;
    stage_amt = AMT_W'(1) << k;
    last_stage = (k == K_W'(AMT_W - 1)) || (((amt_r >> k) >> 1) == '0);

    case (op_r)
      OP_SRL:  stage_val = work >> stage_amt;
      OP_SRA:  stage_val = $unsigned($signed(work) >>> stage_amt);
      default: stage_val = work << stage_amt;  // 00 and reserved 10
    endcase

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          work_nx  = in_data;
          amt_nx   = in_amt;
          op_nx    = in_op;
          k_nx     = '0;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (amt_r[k]) begin
          work_nx = stage_val;
        end
        if (last_stage) begin
          state_nx = S_DONE;
        end else begin
          k_nx = k + K_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    in_ready_nx  = (state_nx == S_IDLE);
    busy_nx      = (state_nx != S_IDLE);
    out_valid_nx = (state_nx == S_DONE);
    out_data_nx  = (state_nx == S_DONE) ? work_nx : '0;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      work      <= '0;
      amt_r     <= '0;
      op_r      <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      work      <= work_nx;
      amt_r     <= amt_nx;
      op_r      <= op_nx;
      k         <= k_nx;
      in_ready  <= in_ready_nx;
      busy      <= busy_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// requests against a whole-shift reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.WIDTH(64), .AMT_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Whole shift in one step, as the result must appear to the consumer
  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [63:0] d,
                                            input logic [5:0] amt);
    case (op)
      2'b01:   return d >> amt;
      2'b11:   return $unsigned($signed(d) >>> amt);
      default: return d << amt;
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] amt);
    int h = 0;
    for (int i = 0; i < 6; i++) if (amt[i]) h = i;
    return h + 1;
  endfunction

  task automatic send(input logic [1:0] op, input logic [63:0] d, input logic [5:0] amt);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Counts edges from accept to out_valid; optionally scribbles on the inputs meanwhile
  task automatic wait_result(input int lat_exp, input logic [63:0] exp, input bit noisy);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (noisy) begin
        in_valid = 1'($urandom); in_data = {$urandom, $urandom};
        in_amt = 6'($urandom); in_op = 2'($urandom);
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'(lat_exp));
    check("result", out_data, exp);
  endtask

  // Holds back-pressure for bp cycles, then retires the result
  task automatic retire(input int bp, input logic [63:0] exp, input bit noisy, input bit keep_valid);
    for (int i = 0; i < bp; i++) begin
      if (noisy) begin
        in_valid = 1'($urandom); in_data = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      check("hold_data", out_data, exp);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = keep_valid;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("retire_valid", 64'(out_valid), 64'd0);
    check("retire_data", out_data, 64'd0);
    check("retire_in_ready", 64'(in_ready), 64'd1);
    check("retire_no_accept", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [63:0] d, input logic [5:0] amt,
                     input int bp, input bit noisy);
    logic [63:0] exp = ref_shift(op, d, amt);
    out_ready = (bp == 0);
    send(op, d, amt);
    wait_result(ref_lat(amt), exp, noisy);
    retire(bp, exp, noisy, 1'b0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;

    run(2'b00, 64'h0000_0000_0000_0001, 6'd63, 0, 1'b0);
    run(2'b11, 64'h8000_0000_0000_0000, 6'd4, 0, 1'b0);
    run(2'b01, 64'h8000_0000_0000_0000, 6'd4, 0, 1'b0);
    run(2'b01, 64'hDEAD_BEEF_0000_0000, 6'd0, 0, 1'b0);
    run(2'b10, 64'h0123_4567_89AB_CDEF, 6'd1, 0, 1'b0);
    check("sra_literal", ref_shift(2'b11, 64'h8000_0000_0000_0000, 6'd4), 64'hF800_0000_0000_0000);

    // Back-pressure with noisy inputs; in_valid held through the retire edge
    out_ready = 1'b0;
    send(2'b00, 64'h0000_0000_0000_00FF, 6'd8);
    wait_result(4, 64'h0000_0000_0000_FF00, 1'b0);
    retire(10, 64'h0000_0000_0000_FF00, 1'b1, 1'b1);

    // Reset during stage 2 of an amt-63 request abandons it
    out_ready = 1'b1;
    send(2'b00, 64'd1, 6'd63);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_data", out_data, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);
    run(2'b00, 64'd1, 6'd1, 0, 1'b0);
    check("post_rst_literal", ref_shift(2'b00, 64'd1, 6'd1), 64'd2);

    // Randomized requests with random back-pressure and input noise
    for (int t = 0; t < 60; t++) begin
      run(2'($urandom), {$urandom, $urandom}, 6'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
